// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO register pair
// Optional build macro: MULTDIV_FAST_MUL_EN (single-cycle multiplier; divide unchanged)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [4:0]       iControlSignal,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oStall,
  output logic             oDone,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic [WIDTH-1:0] oResult
);

  // Operation codes shared with the ALU control decoder
  localparam logic [4:0] OPMULT  = 5'h10;
  localparam logic [4:0] OPMULTU = 5'h11;
  localparam logic [4:0] OPDIV   = 5'h12;
  localparam logic [4:0] OPDIVU  = 5'h13;
  localparam logic [4:0] OPMTHI  = 5'h14;
  localparam logic [4:0] OPMTLO  = 5'h15;
  localparam logic [4:0] OPMFHI  = 5'h16;
  localparam logic [4:0] OPMFLO  = 5'h17;

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_a;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;   // negate product / quotient
  logic               r_neg_r;   // negate remainder (sign of dividend)
  logic               r_is_div;
  logic               r_done;

  logic               w_hilo_op;
  logic               w_signed_op;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_hilo_op   = (iControlSignal >= OPMULT) && (iControlSignal <= OPMFLO);
  assign w_signed_op = (iControlSignal == OPMULT) || (iControlSignal == OPDIV);
  // Signed ops work on magnitudes; the most negative value maps onto itself as unsigned
  assign w_a_abs     = (w_signed_op && iA[WIDTH-1]) ? (~iA + 1'b1) : iA;
  assign w_b_abs     = (w_signed_op && iB[WIDTH-1]) ? (~iB + 1'b1) : iB;

  // Shift-add step: add multiplicand to upper half when the current multiplier bit is set
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  // Restoring-division step: bring down the next dividend bit and trial-subtract
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_a};
  assign w_div_ok    = ~w_div_diff[WIDTH];

  assign w_prod_fix  = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix   = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix   = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULTDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_a_abs} * {{WIDTH{1'b0}}, w_b_abs};
`endif

  assign oBusy   = (r_state != IDLE);
  assign oStall  = iStart && oBusy && w_hilo_op;
  assign oDone   = r_done;
  assign oHI     = r_hi;
  assign oLO     = r_lo;
  assign oResult = (iControlSignal == OPMFHI) ? r_hi :
                   (iControlSignal == OPMFLO) ? r_lo : {WIDTH{1'b0}};

  // Control FSM with iteration datapath and HI/LO ownership
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (iStart) begin
            case (iControlSignal)
              OPMTHI: r_hi <= iA;
              OPMTLO: r_lo <= iA;
              OPMULT, OPMULTU: begin
                r_neg_q  <= w_signed_op && (iA[WIDTH-1] ^ iB[WIDTH-1]);
                r_neg_r  <= w_signed_op && iA[WIDTH-1];
                r_is_div <= 1'b0;
                r_a      <= w_a_abs;
                r_cnt    <= '0;
`ifdef MULTDIV_FAST_MUL_EN
                r_acc    <= w_fast_prod;
                r_state  <= FIX;
`else
                r_acc    <= {{WIDTH{1'b0}}, w_b_abs};
                r_state  <= MUL;
`endif
              end
              OPDIV, OPDIVU: begin
                if (iB == '0) begin
                  // Divide by zero skips iteration and reports a fixed result
                  r_hi   <= iA;
                  r_lo   <= {WIDTH{1'b1}};
                  r_done <= 1'b1;
                end else begin
                  r_neg_q  <= w_signed_op && (iA[WIDTH-1] ^ iB[WIDTH-1]);
                  r_neg_r  <= w_signed_op && iA[WIDTH-1];
                  r_is_div <= 1'b1;
                  r_a      <= w_b_abs;
                  r_acc    <= {{WIDTH{1'b0}}, w_a_abs};
                  r_cnt    <= '0;
                  r_state  <= DIV;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
        end
        DIV: begin
          r_acc <= w_div_ok ? {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                            : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
        end
        FIX: begin
          if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  localparam logic [4:0] OPMULT  = 5'h10;
  localparam logic [4:0] OPMULTU = 5'h11;
  localparam logic [4:0] OPDIV   = 5'h12;
  localparam logic [4:0] OPDIVU  = 5'h13;
  localparam logic [4:0] OPMTHI  = 5'h14;
  localparam logic [4:0] OPMTLO  = 5'h15;
  localparam logic [4:0] OPMFHI  = 5'h16;
  localparam logic [4:0] OPMFLO  = 5'h17;

`ifdef MULTDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iStart = 1'b0;
  logic [4:0]  iControlSignal = 5'd0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        oBusy, oStall, oDone;
  logic [31:0] oHI, oLO, oResult;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iControlSignal(iControlSignal),
    .iA(iA), .iB(iB), .oBusy(oBusy), .oStall(oStall), .oDone(oDone),
    .oHI(oHI), .oLO(oLO), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: HI/LO outcome from plain arithmetic
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (op)
      OPMTHI: m_hi = a;
      OPMTLO: m_lo = a;
      OPMULT: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      OPMULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OPDIV, OPDIVU: begin
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFFFFFF; end
        else if (op == OPDIVU) begin m_lo = a / b; m_hi = a % b; end
        else begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
    if (op == OPMULT || op == OPMULTU) return MUL_LAT;
    if (b == 0) return 0;
    return DIV_LAT;
  endfunction

  // Called at a negedge; returns at the negedge after the issue edge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    iStart = 1'b1; iControlSignal = op; iA = a; iB = b;
    @(negedge iCLK);
    iStart = 1'b0; iControlSignal = 5'd0;
  endtask

  // Edges after the issue edge until oDone is seen; -1 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    while (!oDone && lat < 200) begin
      @(negedge iCLK);
      lat++;
    end
    if (!oDone) lat = -1;
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    issue(op, a, b);
    model(op, a, b);
    if (op == OPMULT || op == OPMULTU || op == OPDIV || op == OPDIVU) begin
      wait_done(lat);
      check({name, " latency"}, 64'(lat), 64'(exp_lat(op, b)));
    end
    check({name, " HI"}, {32'd0, oHI}, {32'd0, m_hi});
    check({name, " LO"}, {32'd0, oLO}, {32'd0, m_lo});
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int stall_err;
    int n;
    vecs[0] = '{OPMULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
    vecs[1] = '{OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[2] = '{OPDIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vecs[3] = '{OPDIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT};
    vecs[4] = '{OPDIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0};
    vecs[5] = '{OPDIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DIV_LAT};
    vecs[6] = '{OPDIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT};
    vecs[7] = '{OPMULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};

    repeat (3) @(negedge iCLK);
    check("reset busy", {63'd0, oBusy}, 64'd0);
    check("reset done", {63'd0, oDone}, 64'd0);
    check("reset HI", {32'd0, oHI}, 64'd0);
    check("reset LO", {32'd0, oLO}, 64'd0);
    iRST_n = 1'b1;
    @(negedge iCLK);

    issue(OPMTHI, 32'h12345678, 32'd0);
    check("mthi HI", {32'd0, oHI}, 64'h12345678);
    issue(OPMTLO, 32'h9ABCDEF0, 32'd0);
    check("mtlo LO", {32'd0, oLO}, 64'h9ABCDEF0);
    check("mtlo HI kept", {32'd0, oHI}, 64'h12345678);
    check("mt busy", {63'd0, oBusy}, 64'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d HI", i), {32'd0, oHI}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d LO", i), {32'd0, oLO}, {32'd0, vecs[i].lo});
      m_hi = vecs[i].hi; m_lo = vecs[i].lo;
    end

    // HI/LO hold while a divide iterates, then MFLO stalls until the result lands
    issue(OPDIVU, 32'd1000, 32'd9);
    repeat (9) @(negedge iCLK);
    check("hold HI in DIV", {32'd0, oHI}, {32'd0, m_hi});
    iStart = 1'b1; iControlSignal = OPMFLO;
    #1;
    check("stall while busy", {63'd0, oStall}, 64'd1);
    stall_err = 0; n = 0;
    while (!oDone && n < 200) begin
      if (!oStall) stall_err++;
      @(negedge iCLK);
      n++;
    end
    check("stall held until done", 64'(stall_err), 64'd0);
    check("stall done seen", {63'd0, oDone}, 64'd1);
    check("stall released", {63'd0, oStall}, 64'd0);
    check("mflo result", {32'd0, oResult}, 64'd111);
    iControlSignal = OPMFHI;
    #1;
    check("mfhi result", {32'd0, oResult}, 64'd1);
    @(negedge iCLK);
    iStart = 1'b0; iControlSignal = 5'd0;
    check("mf no state change", {63'd0, oBusy}, 64'd0);
    m_hi = 32'd1; m_lo = 32'd111;

    // Back-to-back issue in the oDone cycle
    issue(OPMULTU, 32'd6, 32'd7);
    wait_done(lat);
    model(OPMULTU, 32'd6, 32'd7);
    issue(OPDIVU, 32'd50, 32'd0);
    check("b2b div0 HI", {32'd0, oHI}, 64'd50);
    check("b2b div0 LO", {32'd0, oLO}, 64'hFFFFFFFF);
    m_hi = 32'd50; m_lo = 32'hFFFFFFFF;

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 5))
        0: op = OPMULT;
        1: op = OPMULTU;
        2: op = OPDIV;
        3: op = OPDIVU;
        4: op = OPMTHI;
        default: op = OPMTLO;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 2000));
      run_op($sformatf("rand%0d op%0h", i, op), op, a, b);
    end

    // Reset mid-divide aborts immediately
    issue(OPDIV, 32'hFFFF0000, 32'd3);
    repeat (14) @(negedge iCLK);
    iRST_n = 1'b0;
    #1;
    check("abort busy", {63'd0, oBusy}, 64'd0);
    check("abort HI", {32'd0, oHI}, 64'd0);
    check("abort LO", {32'd0, oLO}, 64'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone || oBusy) n++;
    end
    check("no done after abort", 64'(n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
